// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN datapath blocks.
// The default widths match the 8-bit pixel, Q1.7 coefficient and 24-bit accumulator datapath.
package cnn_pkg;

    localparam int PIX_W         = 8;
    localparam int COEF_W        = 8;
    localparam int ACC_W         = 24;
    localparam int WIN_TAPS      = 9;
    localparam int CFG_ADDR_BIAS = 9;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef pix_t                     window_t [0:WIN_TAPS-1];

endpackage

// File: rtl/conv3x3_mac_if.sv
// Window stream, config port and result bundle of conv3x3_mac.
// The master side drives windows and config writes; the slave side is the MAC.
interface conv3x3_mac_if #(
    parameter int DATA_WIDTH = cnn_pkg::PIX_W
);
    import cnn_pkg::*;

    logic                         i_valid;
    logic        [DATA_WIDTH-1:0] i_window [0:WIN_TAPS-1];
    logic                         cfg_we;
    logic        [3:0]            cfg_addr;
    logic        [15:0]           cfg_wdata;
    logic                         o_valid;
    logic signed [DATA_WIDTH-1:0] o_data;
    logic                         o_sat;
    logic                         o_last;

    modport master (
        output i_valid, i_window, cfg_we, cfg_addr, cfg_wdata,
        input  o_valid, o_data, o_sat, o_last
    );

    modport slave (
        input  i_valid, i_window, cfg_we, cfg_addr, cfg_wdata,
        output o_valid, o_data, o_sat, o_last
    );

endinterface

// File: rtl/conv_sat_round.sv
// Combinational round-half-up, arithmetic shift and saturation of the accumulator.
// With CONV_RELU_EN defined, negative results clamp to 0 without flagging saturation.
module conv_sat_round import cnn_pkg::*; #(
    parameter int ACC_WIDTH  = ACC_W,
    parameter int DATA_WIDTH = PIX_W,
    parameter int OUT_SHIFT  = 7
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] data,
    output logic                         sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shifted;

    assign ext = {acc[ACC_WIDTH-1], acc};

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = EXT_W'(64'd1 << (OUT_SHIFT - 1));
            assign shifted = (ext + HALF) >>> OUT_SHIFT;
        end else begin : g_no_round
            assign shifted = ext;
        end
    endgenerate

    always_comb begin
        data = '0;
        sat  = 1'b0;
        if (shifted > MAX_V) begin
            data = MAX_V[DATA_WIDTH-1:0];
            sat  = 1'b1;
        end
`ifdef CONV_RELU_EN
        else if (shifted[EXT_W-1]) begin
            data = '0;
        end
`else
        else if (shifted < MIN_V) begin
            data = MIN_V[DATA_WIDTH-1:0];
            sat  = 1'b1;
        end
`endif
        else begin
            data = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_mac.sv
// Four-stage 3x3 signed MAC with bias, rounding, saturation and a frame-end marker.
// Build option CONV_RELU_EN (in conv_sat_round) clamps negative results to zero.
module conv3x3_mac import cnn_pkg::*; #(
    parameter int DATA_WIDTH    = PIX_W,
    parameter int COEF_WIDTH    = COEF_W,
    parameter int ACC_WIDTH     = ACC_W,
    parameter int OUT_SHIFT     = 7,
    parameter int OUT_PER_FRAME = 676
) (
    input  logic          clk,
    input  logic          rst_n,
    conv3x3_mac_if.slave  bus
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int CNT_W  = $clog2(OUT_PER_FRAME);

    typedef logic signed [COEF_WIDTH-1:0] coef_w_t;
    typedef logic signed [PROD_W-1:0]     prod_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_w_t;

    coef_w_t            coef [WIN_TAPS];
    logic signed [15:0] bias;

    logic               s1_valid, s2_valid, s3_valid;
    prod_t              s1_prod [WIN_TAPS];
    logic signed [15:0] s1_bias, s2_bias;
    acc_w_t             s2_row [3];
    acc_w_t             s3_acc;
    logic [CNT_W-1:0]   frame_cnt;

    logic signed [DATA_WIDTH-1:0] sat_data;
    logic                         sat_flag;

    // Register bank; S1 samples the old values on a write edge because both are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIN_TAPS; k++) coef[k] <= '0;
            bias <= '0;
        end else if (bus.cfg_we) begin
            for (int k = 0; k < WIN_TAPS; k++)
                if (bus.cfg_addr == 4'(k)) coef[k] <= bus.cfg_wdata[COEF_WIDTH-1:0];
            if (bus.cfg_addr == 4'(CFG_ADDR_BIAS)) bias <= bus.cfg_wdata;
        end
    end

    // S1..S3: products with bias snapshot, row sums, final accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            for (int k = 0; k < WIN_TAPS; k++) s1_prod[k] <= '0;
            for (int r = 0; r < 3; r++) s2_row[r] <= '0;
            s1_bias  <= '0;
            s2_bias  <= '0;
            s3_acc   <= '0;
        end else begin
            s1_valid <= bus.i_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (bus.i_valid) begin
                for (int k = 0; k < WIN_TAPS; k++)
                    s1_prod[k] <= prod_t'($signed({1'b0, bus.i_window[k]})) * prod_t'(coef[k]);
                s1_bias <= bias;
            end
            for (int r = 0; r < 3; r++)
                s2_row[r] <= acc_w_t'(s1_prod[3*r]) + acc_w_t'(s1_prod[3*r+1])
                           + acc_w_t'(s1_prod[3*r+2]);
            s2_bias <= s1_bias;
            s3_acc  <= s2_row[0] + s2_row[1] + s2_row[2] + acc_w_t'(s2_bias);
        end
    end

    conv_sat_round #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_SHIFT  (OUT_SHIFT)
    ) u_sat_round (
        .acc  (s3_acc),
        .data (sat_data),
        .sat  (sat_flag)
    );

    // S4 output register and frame counter, which advances once per result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_sat   <= 1'b0;
            bus.o_last  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            bus.o_valid <= s3_valid;
            bus.o_data  <= sat_data;
            bus.o_sat   <= s3_valid & sat_flag;
            bus.o_last  <= s3_valid && (frame_cnt == CNT_W'(OUT_PER_FRAME - 1));
            if (s3_valid)
                frame_cnt <= (frame_cnt == CNT_W'(OUT_PER_FRAME - 1)) ? '0 : frame_cnt + 1'b1;
        end
    end

endmodule
